mac_encap: RTL and testbench

Transmit-side MAC frame encapsulation. The block accepts a frame (destination, source, type/length, payload; no FCS) on an AXI-Stream byte interface. It drives a byte-wide GMII transmit port with:
- 7-byte preamble and SFD
- the frame data, zero-padded to the minimum frame length
- a CRC-32 FCS
- an enforced inter-frame gap

It is the counterpart of the receive-side decapsulation block and shares its frame-length conventions.

---
 rtl/mac_encap.sv | 231 +++++++++++++++++++++++
 tb/tb_mac_encap.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_encap.sv
// Transmit MAC encapsulation: AXI-Stream frame bytes in, GMII out with preamble/SFD,
// zero padding to minimum length, CRC-32 FCS and an enforced inter-frame gap.
module mac_encap #(
   parameter int MIN_PAYLOAD_LENGTH = 46,
   parameter int MAX_PAYLOAD_LENGTH = 1500,
   parameter int IFG_LENGTH         = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tdata,
   input  logic       tvalid,
   output logic       tready,
   input  logic       tuser,
   input  logic       tlast,
   input  logic [1:0] speed_mode,
   output logic [7:0] gmii_txd,
   output logic       gmii_txen,
   output logic       gmii_txer
);

   localparam int MIN_FRAME_LENGTH = MIN_PAYLOAD_LENGTH + 14;
   localparam int MAX_FRAME_LENGTH = MAX_PAYLOAD_LENGTH + 14;
   localparam int CNT_W            = $clog2(MAX_FRAME_LENGTH + 1);
   localparam int SLOT_W           = $clog2(IFG_LENGTH + 8);

   localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_FRAME_LENGTH);
   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_FRAME_LENGTH);
   localparam logic [SLOT_W-1:0] IFG_LAST = SLOT_W'(IFG_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      PAD,
      FCS,
      DRAIN,
      IFG
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        pace_q, pace_d, pace_max;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [31:0]       crc_q, crc_d;
   logic [7:0]        txd_q, txd_d;
   logic              txen_q, txen_d;
   logic              txer_q, txer_d;
   logic              strobe;

   // Reflected IEEE 802.3 CRC-32, one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
      end
      return r;
   endfunction

   // Slot pacing: the counter stays parked at 0 while idle so a new frame starts at once.
   always_comb begin
      case (speed_mode)
         2'b01:   pace_max = 7'd9;
         2'b00:   pace_max = 7'd99;
         default: pace_max = 7'd0;
      endcase
      strobe = (pace_q == 7'd0);
      if (state_q == IDLE && !tvalid) begin
         pace_d = 7'd0;
      end else if (pace_q >= pace_max) begin
         pace_d = 7'd0;
      end else begin
         pace_d = pace_q + 7'd1;
      end
   end

   assign tready    = (state_q == DATA && strobe) || (state_q == DRAIN);
   assign gmii_txd  = txd_q;
   assign gmii_txen = txen_q;
   assign gmii_txer = txer_q;
   assign cnt_inc   = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      slot_d  = slot_q;
      crc_d   = crc_q;
      txd_d   = txd_q;
      txen_d  = txen_q;
      txer_d  = txer_q;

      case (state_q)
         IDLE: begin
            if (strobe) begin
               txd_d  = 8'h00;
               txen_d = 1'b0;
               txer_d = 1'b0;
               if (tvalid) begin
                  state_d = PREAMBLE;
                  txd_d   = 8'h55;
                  txen_d  = 1'b1;
                  slot_d  = SLOT_W'(1);
               end
            end
         end

         PREAMBLE: begin
            if (strobe) begin
               txen_d = 1'b1;
               txer_d = 1'b0;
               if (slot_q == SLOT_W'(7)) begin
                  txd_d   = 8'hD5;
                  state_d = DATA;
                  crc_d   = 32'hFFFFFFFF;
                  cnt_d   = '0;
                  slot_d  = '0;
               end else begin
                  txd_d  = 8'h55;
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end

         DATA: begin
            if (strobe) begin
               txen_d = 1'b1;
               if (tvalid) begin
                  txd_d  = tdata;
                  txer_d = tuser;
                  crc_d  = crc_byte(crc_q, tdata);
                  cnt_d  = cnt_inc;
                  if (tlast) begin
                     state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
                     slot_d  = '0;
                  end else if (cnt_q == MAX_CNT) begin
                     txer_d  = 1'b1;
                     state_d = DRAIN;
                  end
               end else begin
                  // Source starved mid-frame: poison the slot and abandon the frame.
                  txd_d   = 8'h00;
                  txer_d  = 1'b1;
                  state_d = DRAIN;
               end
            end
         end

         PAD: begin
            if (strobe) begin
               txd_d  = 8'h00;
               txen_d = 1'b1;
               txer_d = 1'b0;
               crc_d  = crc_byte(crc_q, 8'h00);
               cnt_d  = cnt_inc;
               if (cnt_inc == MIN_CNT) begin
                  state_d = FCS;
                  slot_d  = '0;
               end
            end
         end

         FCS: begin
            if (strobe) begin
               txd_d  = ~crc_q[7:0];
               txen_d = 1'b1;
               txer_d = 1'b0;
               crc_d  = crc_q >> 8;
               if (slot_q == SLOT_W'(3)) begin
                  state_d = IFG;
                  slot_d  = '0;
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end

         DRAIN: begin
            if (strobe) begin
               txd_d  = 8'h00;
               txen_d = 1'b0;
               txer_d = 1'b0;
            end
            if (tvalid && tlast) begin
               state_d = IFG;
               slot_d  = '0;
            end
         end

         IFG: begin
            if (strobe) begin
               txd_d  = 8'h00;
               txen_d = 1'b0;
               txer_d = 1'b0;
               if (slot_q == IFG_LAST) begin
                  state_d = IDLE;
                  slot_d  = '0;
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pace_q  <= 7'd0;
         cnt_q   <= '0;
         slot_q  <= '0;
         crc_q   <= 32'hFFFFFFFF;
         txd_q   <= 8'h00;
         txen_q  <= 1'b0;
         txer_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pace_q  <= pace_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         crc_q   <= crc_d;
         txd_q   <= txd_d;
         txen_q  <= txen_d;
         txer_q  <= txer_d;
      end
   end

endmodule

// File: tb/tb_mac_encap.sv
// Bench for mac_encap: random frames against a slot-level model of the GMII stream.
module tb_mac_encap;

   localparam int MIN_FRAME = 60;
   localparam int MAX_FRAME = 1514;
   localparam int IFG       = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tuser;
   logic       tlast;
   logic [1:0] speed_mode;
   logic [7:0] gmii_txd;
   logic       gmii_txen;
   logic       gmii_txer;

   always #5 clk = ~clk;

   mac_encap dut (
      .clk        (clk),
      .reset      (reset),
      .tdata      (tdata),
      .tvalid     (tvalid),
      .tready     (tready),
      .tuser      (tuser),
      .tlast      (tlast),
      .speed_mode (speed_mode),
      .gmii_txd   (gmii_txd),
      .gmii_txen  (gmii_txen),
      .gmii_txer  (gmii_txer)
   );

   typedef struct packed { logic [7:0] d; logic last; logic user; } beat_t;
   typedef struct packed { logic [7:0] d; logic er; logic chk; } slot_t;

   beat_t       in_q[$];
   beat_t       saved_in[$];
   slot_t       exp_q[$];
   slot_t       saved_exp[$];
   int          exp_len[$];
   bit          exp_ok[$];
   int          drop_idx;
   bit          drv_abort;
   bit          mon_en;
   logic [7:0]  m_txd[$];
   logic        m_txen[$];
   logic        m_txer[$];
   logic        m_rdy[$];
   int          checks;
   int          errors;
   logic [31:0] crc_tab[256];
   logic [31:0] last_fcs;
   logic [31:0] fcs_1000;

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         m_txd.push_back(gmii_txd);
         m_txen.push_back(gmii_txen);
         m_txer.push_back(gmii_txer);
         m_rdy.push_back(tready);
      end
   end

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      return (c >> 8) ^ crc_tab[c[7:0] ^ d];
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int b = 0; b < 32; b++) r[b] = v[31-b];
      return r;
   endfunction

   task automatic clear_all();
      in_q.delete(); exp_q.delete(); exp_len.delete(); exp_ok.delete();
      m_txd.delete(); m_txen.delete(); m_txer.delete(); m_rdy.delete();
      drop_idx = -1;
   endtask

   // kind 0 = good frame, 1 = underrun before byte k, 2 = oversize (len > MAX_FRAME)
   task automatic add_frame(input int len, input int kind, input int k, input int user_at, input int fixed0);
      logic [7:0]  data[$];
      logic [31:0] c;
      for (int i = 0; i < len; i++) begin
         beat_t b;
         b.d    = (i == 0 && fixed0 >= 0) ? 8'(fixed0) : 8'($urandom);
         b.last = (i == len - 1);
         b.user = (i == user_at);
         in_q.push_back(b);
         data.push_back(b.d);
      end
      for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, 1'b0, 1'b1});
      exp_q.push_back('{8'hD5, 1'b0, 1'b1});
      if (kind == 0) begin
         while (data.size() < MIN_FRAME) data.push_back(8'h00);
         c = 32'hFFFFFFFF;
         for (int i = 0; i < data.size(); i++) begin
            c = crc_step(c, data[i]);
            exp_q.push_back('{data[i], 1'(i == user_at), 1'b1});
         end
         c = ~c;
         for (int j = 0; j < 4; j++) exp_q.push_back('{c[8*j +: 8], 1'b0, 1'b1});
         exp_len.push_back(8 + data.size() + 4);
      end else if (kind == 1) begin
         for (int i = 0; i < k; i++) exp_q.push_back('{data[i], 1'(i == user_at), 1'b1});
         exp_q.push_back('{8'h00, 1'b1, 1'b0});
         exp_len.push_back(8 + k + 1);
         drop_idx = in_q.size() - len + k;
      end else begin
         for (int i = 0; i <= MAX_FRAME; i++)
            exp_q.push_back('{data[i], 1'((i == MAX_FRAME) || (i == user_at)), 1'b1});
         exp_len.push_back(8 + MAX_FRAME + 1);
      end
      exp_ok.push_back(kind == 0);
   endtask

   task automatic drive_all();
      int idx = 0;
      int guard = 0;
      bit dropped = 0;
      while (idx < in_q.size() && !drv_abort && guard < 40000) begin
         @(negedge clk);
         guard++;
         if (idx == drop_idx && !dropped && tready) begin
            tvalid  = 1'b0;
            dropped = 1;
         end else begin
            tdata  = in_q[idx].d;
            tlast  = in_q[idx].last;
            tuser  = in_q[idx].user;
            tvalid = 1'b1;
            if (tready) idx++;
         end
      end
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      if (guard >= 40000) begin
         checks++; errors++;
         $display("FAIL drive_timeout accepted %0d of %0d beats", idx, in_q.size());
      end
   endtask

   task automatic wait_idle(input int quiet);
      int q = 0;
      int g = 0;
      while (q < quiet && g < 20000) begin
         @(posedge clk); #2;
         g++;
         q = gmii_txen ? 0 : q + 1;
      end
      if (g >= 20000) begin
         checks++; errors++;
         $display("FAIL idle_timeout txen still active after %0d cycles", g);
      end
   endtask

   task automatic analyze(input int div, input string name);
      slot_t got[$];
      int    seg_st[$];
      int    seg_len[$];
      int    gaps[$];
      int    i = 0;
      int    gap = -1;
      int    hold_bad = 0;
      int    pe = 0;
      int    n = m_txen.size();
      while (i < n) begin
         if (m_txen[i] === 1'b1) begin
            int st = i;
            if (gap >= 0) gaps.push_back(gap / div);
            while (i < n && m_txen[i] === 1'b1) i++;
            seg_st.push_back(got.size());
            seg_len.push_back((i - st) / div);
            if ((i - st) % div != 0) hold_bad++;
            for (int s = st; s + div <= i; s += div) begin
               got.push_back('{m_txd[s], m_txer[s], 1'b1});
               for (int t = s + 1; t < s + div; t++)
                  if (m_txd[t] !== m_txd[s] || m_txer[t] !== m_txer[s]) hold_bad++;
            end
            gap = 0;
         end else begin
            if (gap >= 0) gap++;
            i++;
         end
      end
      checks++;
      if (seg_len.size() != exp_len.size()) begin
         errors++;
         $display("FAIL %s_frames got %0d want %0d", name, seg_len.size(), exp_len.size());
      end
      for (int f = 0; f < seg_len.size() && f < exp_len.size(); f++) begin
         int          bad = 0;
         int          first = -1;
         logic [31:0] c;
         checks++;
         if (seg_len[f] != exp_len[f]) begin
            errors++;
            $display("FAIL %s_len frame %0d got %0d want %0d", name, f, seg_len[f], exp_len[f]);
         end
         for (int j = 0; j < seg_len[f] && j < exp_len[f]; j++) begin
            slot_t g = got[seg_st[f] + j];
            slot_t e = exp_q[pe + j];
            if ((e.chk && g.d !== e.d) || g.er !== e.er) begin
               bad++;
               if (first < 0) first = j;
            end
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s_bytes frame %0d slot %0d got %h/er%b want %h/er%b (%0d bad)", name, f, first,
                     got[seg_st[f] + first].d, got[seg_st[f] + first].er,
                     exp_q[pe + first].d, exp_q[pe + first].er, bad);
         end
         if (exp_ok[f] && seg_len[f] >= 12) begin
            c = 32'hFFFFFFFF;
            for (int j = 8; j < seg_len[f]; j++) c = crc_step(c, got[seg_st[f] + j].d);
            checks++;
            if (rev32(c) !== 32'hC704DD7B) begin
               errors++;
               $display("FAIL %s_residue frame %0d got %h want c704dd7b", name, f, rev32(c));
            end
         end
         if (f == 0 && seg_len[f] >= 4)
            for (int j = 0; j < 4; j++) last_fcs[8*j +: 8] = got[seg_st[f] + seg_len[f] - 4 + j].d;
         pe += exp_len[f];
      end
      for (int g = 0; g < gaps.size() && g < exp_ok.size(); g++) begin
         checks++;
         if (exp_ok[g] ? (gaps[g] != IFG) : (gaps[g] < IFG)) begin
            errors++;
            $display("FAIL %s_gap after frame %0d got %0d want %s%0d", name, g, gaps[g],
                     exp_ok[g] ? "" : ">=", IFG);
         end
      end
      if (div > 1) begin
         checks++;
         if (hold_bad != 0) begin
            errors++;
            $display("FAIL %s_hold got %0d unstable slots want 0", name, hold_bad);
         end
      end
   endtask

   task automatic run_set(input int div, input string name);
      mon_en = 1;
      drive_all();
      wait_idle(200);
      mon_en = 0;
      analyze(div, name);
   endtask

   task automatic test_reset();
      reset = 1'b1; tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0; speed_mode = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (gmii_txen !== 1'b0) begin errors++; $display("FAIL reset_txen got %b want 0", gmii_txen); end
      checks++; if (gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %h want 00", gmii_txd); end
      checks++; if (gmii_txer !== 1'b0) begin errors++; $display("FAIL reset_txer got %b want 0", gmii_txer); end
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", tready); end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_1000();
      clear_all();
      add_frame(60, 0, 0, -1, -1);
      saved_in  = in_q;
      saved_exp = exp_q;
      mon_en = 1;
      @(negedge clk);
      tdata = in_q[0].d; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (gmii_txen !== 1'b1 || gmii_txd !== 8'h55) begin
         errors++;
         $display("FAIL latency got txen %b txd %h want 1 55", gmii_txen, gmii_txd);
      end
      run_set(1, "basic");
      fcs_1000 = last_fcs;
   endtask

   task automatic test_short_frames();
      clear_all();
      add_frame(1, 0, 0, -1, 8'hAB);
      add_frame($urandom_range(59, 2), 0, 0, 1, -1);
      add_frame($urandom_range(200, 60), 0, 0, -1, -1);
      add_frame(59, 0, 0, 58, -1);
      run_set(1, "short");
   endtask

   task automatic test_underrun();
      clear_all();
      add_frame(100, 1, $urandom_range(80, 10), -1, -1);
      add_frame(70, 0, 0, -1, -1);
      run_set(1, "underrun");
   endtask

   task automatic test_oversize();
      clear_all();
      add_frame(MAX_FRAME, 0, 0, -1, -1);
      add_frame(MAX_FRAME + 6, 2, 0, -1, -1);
      add_frame(64, 0, 0, -1, -1);
      run_set(1, "oversize");
   endtask

   task automatic test_speed_100();
      int rdy = 0;
      int last_r = -1;
      int sp_bad = 0;
      clear_all();
      speed_mode = 2'b01;
      in_q  = saved_in;
      exp_q = saved_exp;
      exp_len.push_back(72);
      exp_ok.push_back(1'b1);
      run_set(10, "speed100");
      for (int i = 0; i < m_rdy.size(); i++) begin
         if (m_rdy[i] === 1'b1) begin
            if (last_r >= 0 && i - last_r != 10) sp_bad++;
            last_r = i;
            rdy++;
         end
      end
      checks++;
      if (rdy != 60) begin errors++; $display("FAIL speed100_tready_count got %0d want 60", rdy); end
      checks++;
      if (sp_bad != 0) begin errors++; $display("FAIL speed100_tready_spacing got %0d bad want 0", sp_bad); end
      checks++;
      if (last_fcs !== fcs_1000) begin
         errors++;
         $display("FAIL speed100_fcs got %h want %h", last_fcs, fcs_1000);
      end
      speed_mode = 2'b10;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      clear_all();
      add_frame(120, 0, 0, -1, -1);
      fork
         drive_all();
         begin
            repeat (30) @(negedge clk);
            reset = 1'b1;
            drv_abort = 1;
            @(posedge clk); #1;
            checks++;
            if (gmii_txen !== 1'b0 || tready !== 1'b0 || gmii_txd !== 8'h00) begin
               errors++;
               $display("FAIL midreset got txen %b tready %b txd %h want 0 0 00", gmii_txen, tready, gmii_txd);
            end
         end
      join
      @(negedge clk);
      reset = 1'b0;
      drv_abort = 0;
      repeat (2) @(negedge clk);
      clear_all();
      add_frame($urandom_range(90, 30), 0, 0, -1, -1);
      run_set(1, "after_reset");
   endtask

   initial begin
      checks = 0; errors = 0; drv_abort = 0; mon_en = 0; drop_idx = -1;
      for (int n = 0; n < 256; n++) begin
         logic [31:0] v;
         v = 32'(n);
         repeat (8) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
         crc_tab[n] = v;
      end
      test_reset();
      test_basic_1000();
      test_short_frames();
      test_underrun();
      test_oversize();
      test_speed_100();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
